// File: rtl/display_page_scheduler_if.sv
// Load handshake, mode controls and page outputs of the 128-bit display page scheduler.
interface display_page_scheduler_if;
  logic           ld_valid;
  logic           ld_ready;
  logic [127:0]   data_in;
  logic           auto_mode;
  logic           freeze;
  logic           btn_next;
  logic [0:15]    x;
  logic [3:0]     page_idx;
  logic           loaded;

  modport master (
    output ld_valid, data_in, auto_mode, freeze, btn_next,
    input  ld_ready, x, page_idx, loaded
  );

  modport slave (
    input  ld_valid, data_in, auto_mode, freeze, btn_next,
    output ld_ready, x, page_idx, loaded
  );
endinterface

// File: rtl/display_page_scheduler.sv
// Pages a 128-bit value onto the 16-bit display word, advancing on a dwell timer or debounced button.
// Define DISP_CHECKSUM_EN to add a ninth page showing the XOR of the eight data words.
module display_page_scheduler #(
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DWELL_W         = 26,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DEBOUNCE_W      = 20
) (
  input  logic                      clk,
  input  logic                      clr,
  display_page_scheduler_if.slave   bus
);

  // state  | meaning: IDLE = nothing loaded | SHOW = paging | FROZEN = page and loads held
  typedef enum logic [1:0] {IDLE, SHOW, FROZEN} state_t;

`ifdef DISP_CHECKSUM_EN
  localparam logic [3:0] LAST_PAGE = 4'd8;
`else
  localparam logic [3:0] LAST_PAGE = 4'd7;
`endif
  localparam logic [DWELL_W-1:0]    DWELL_TC = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [DEBOUNCE_W-1:0] DB_TC    = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [127:0]            data_q;
  logic [3:0]              page_q, page_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    auto_q;
  logic                    loaded_q;
  logic [15:0]             x_q, word;
  logic                    sync1_q, sync2_q;
  logic [DEBOUNCE_W-1:0]   db_cnt_q;
  logic                    db_last_q, db_acc_q;
  logic                    ld_ready;
  logic                    load, step, advance, dwell_run, db_stable, db_tc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)        state_d = SHOW;
      SHOW:    if (bus.freeze)  state_d = FROZEN;
      FROZEN:  if (!bus.freeze) state_d = SHOW;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ready = (state_q != FROZEN);
  end

  assign load = bus.ld_valid && ld_ready;

  // Step fires on the first cycle a stable high level is accepted; holding the button gives no more.
  assign db_stable = (sync2_q == db_last_q);
  assign db_tc     = (db_cnt_q == DB_TC);
  assign step      = db_stable && db_tc && db_last_q && !db_acc_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      db_last_q <= 1'b0;
      db_acc_q  <= 1'b0;
    end else begin
      sync1_q <= bus.btn_next;
      sync2_q <= sync1_q;
      if (!db_stable) begin
        db_last_q <= sync2_q;
        db_cnt_q  <= '0;
      end else if (!db_tc) begin
        db_cnt_q  <= db_cnt_q + DEBOUNCE_W'(1);
      end else begin
        db_acc_q  <= db_last_q;
      end
    end
  end

  // Dwell only runs while showing in a settled auto mode; every other case parks it at zero.
  assign dwell_run = (state_q == SHOW) && !bus.freeze && bus.auto_mode && auto_q;
  assign advance   = (state_q == SHOW) && !bus.freeze && !load &&
                     (bus.auto_mode ? (dwell_run && dwell_q == DWELL_TC) : step);

  always_comb begin
    dwell_d = '0;
    if (!load && dwell_run && dwell_q != DWELL_TC)
      dwell_d = dwell_q + DWELL_W'(1);
  end

  always_comb begin
    page_d = page_q;
    if (load)
      page_d = 4'd0;
    else if (advance)
      page_d = (page_q == LAST_PAGE) ? 4'd0 : page_q + 4'd1;
  end

  always_comb begin
    word = data_q[{~page_q[2:0], 4'b0000} +: 16];
`ifdef DISP_CHECKSUM_EN
    if (page_q[3]) begin
      word = 16'h0000;
      for (int i = 0; i < 8; i++)
        word = word ^ data_q[16*i +: 16];
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q   <= '0;
      page_q   <= 4'd0;
      dwell_q  <= '0;
      auto_q   <= 1'b0;
      loaded_q <= 1'b0;
      x_q      <= 16'h0000;
    end else begin
      if (load) begin
        data_q   <= bus.data_in;
        loaded_q <= 1'b1;
      end
      page_q  <= page_d;
      dwell_q <= dwell_d;
      auto_q  <= bus.auto_mode;
      x_q     <= word;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.x        = x_q;
  assign bus.page_idx = page_q;
  assign bus.loaded   = loaded_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Directed bench for display_page_scheduler with a short dwell (10) and debounce (4).
module tb_display_page_scheduler;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  display_page_scheduler_if bus ();

  display_page_scheduler #(
    .DWELL_CYCLES    (10),
    .DWELL_W         (4),
    .DEBOUNCE_CYCLES (4),
    .DEBOUNCE_W      (3)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] K2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [127:0] K3 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;

`ifdef DISP_CHECKSUM_EN
  localparam int NPAGE = 9;
  logic [15:0] k1_pages [9] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF, 16'h0000};
`else
  localparam int NPAGE = 8;
  logic [15:0] k1_pages [8] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    clr           = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.data_in   = '0;
    bus.auto_mode = 1'b0;
    bus.freeze    = 1'b0;
    bus.btn_next  = 1'b0;
    #23;
    clr = 1'b0;
    cyc(1);

    // reset state, no load
    cyc(50);
    check("rst_x",        32'(bus.x),        32'h0000);
    check("rst_page",     32'(bus.page_idx), 32'd0);
    check("rst_loaded",   32'(bus.loaded),   32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);

    // load and auto paging with wrap
    bus.auto_mode = 1'b1;
    bus.data_in   = K1;
    bus.ld_valid  = 1'b1;
    cyc(1);
    bus.ld_valid  = 1'b0;
    check("load_loaded", 32'(bus.loaded),   32'd1);
    check("load_page",   32'(bus.page_idx), 32'd0);
    cyc(1);
    check("auto_x0", 32'(bus.x), 32'(k1_pages[0]));
    for (int k = 1; k <= NPAGE; k++) begin
      cyc(10);
      check("auto_page", 32'(bus.page_idx), 32'(k % NPAGE));
      check("auto_x",    32'(bus.x),        32'(k1_pages[k % NPAGE]));
    end

    // manual mode with a bouncing button
    bus.auto_mode = 1'b0;
    bus.btn_next = 1'b1; cyc(1);
    bus.btn_next = 1'b0; cyc(1);
    bus.btn_next = 1'b1; cyc(1);
    cyc(20);
    check("btn_one_step", 32'(bus.page_idx), 32'd1);
    cyc(1);
    check("btn_x", 32'(bus.x), 32'(k1_pages[1]));
    bus.btn_next = 1'b0;
    cyc(10);
    check("btn_release", 32'(bus.page_idx), 32'd1);
    bus.btn_next = 1'b1;
    cyc(10);
    check("btn_repress", 32'(bus.page_idx), 32'd2);
    cyc(15);
    check("btn_held", 32'(bus.page_idx), 32'd2);
    bus.btn_next = 1'b0;
    cyc(10);

    // freeze in auto mode, load attempt ignored
    bus.auto_mode = 1'b1;
    bus.freeze    = 1'b1;
    cyc(1);
    check("frz_ready", 32'(bus.ld_ready), 32'd0);
    cyc(10);
    bus.data_in  = K3;
    bus.ld_valid = 1'b1;
    cyc(1);
    bus.ld_valid = 1'b0;
    cyc(28);
    check("frz_page",  32'(bus.page_idx), 32'd2);
    check("frz_x",     32'(bus.x),        32'(k1_pages[2]));
    bus.freeze = 1'b0;
    cyc(1);
    check("unfrz_ready", 32'(bus.ld_ready), 32'd1);
    check("unfrz_x",     32'(bus.x),        32'(k1_pages[2]));
    cyc(9);
    check("unfrz_hold", 32'(bus.page_idx), 32'd2);
    cyc(1);
    check("unfrz_adv", 32'(bus.page_idx), 32'd3);
    cyc(1);
    check("unfrz_data", 32'(bus.x), 32'(k1_pages[3]));

    // load on the dwell terminal cycle wins over the advance
    cyc(8);
    bus.data_in  = K2;
    bus.ld_valid = 1'b1;
    cyc(1);
    bus.ld_valid = 1'b0;
    check("tc_load_page", 32'(bus.page_idx), 32'd0);
    cyc(1);
    check("tc_load_x", 32'(bus.x), 32'hDEAD);
    cyc(8);
    check("tc_next_hold", 32'(bus.page_idx), 32'd0);
    cyc(1);
    check("tc_next_adv", 32'(bus.page_idx), 32'd1);
    cyc(1);
    check("tc_next_x", 32'(bus.x), 32'hBEEF);

    // asynchronous reset mid-dwell on page 5
    cyc(43);
    check("pre_rst_page", 32'(bus.page_idx), 32'd5);
    #2;
    clr = 1'b1;
    #1;
    check("arst_x",        32'(bus.x),        32'h0000);
    check("arst_page",     32'(bus.page_idx), 32'd0);
    check("arst_loaded",   32'(bus.loaded),   32'd0);
    check("arst_ld_ready", 32'(bus.ld_ready), 32'd1);
    cyc(2);
    clr = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
